// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
// Holds the FSM state enum, RV32I load/store func3 codes and the size-mask helper.
// Imported by lsu and lsu_align.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte mask of the access size, right-aligned: byte/half/word.
  function automatic logic [3:0] size_mask(input logic [2:0] func3);
    case (func3[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Stores only have B/H/W; loads add the unsigned B/H variants.
  function automatic logic f3_legal(input logic we, input logic [2:0] func3);
    if (we) return (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W);
    return (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W) ||
           (func3 == F3_BU) || (func3 == F3_HU);
  endfunction

  // Natural-size misalignment: half on an odd byte, word off a word boundary.
  function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] offset);
    return ((func3[1:0] == 2'b01) && offset[0]) ||
           ((func3[1:0] == 2'b10) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-enable, store-lane and load-extract datapath for the LSU.
// Purely combinational (zero latency); no handshake of its own.
// Beat0 uses the low halves of be8/wlane, beat1 the high halves.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] beat0,
  input  logic [31:0] beat1,
  output logic [7:0]  be8,
  output logic [63:0] wlane,
  output logic [31:0] rdata
);

  logic [3:0]  m;
  logic [31:0] wrep;
  logic [31:0] raw;

  assign m   = size_mask(func3);
  assign be8 = {4'b0000, m} << offset;

  // Replicate store data across the word so every lane carries the right byte(s).
  always_comb begin
    wrep = wdata;
    case (func3[1:0])
      2'b00:   wrep = {4{wdata[7:0]}};
      2'b01:   wrep = {2{wdata[15:0]}};
      default: wrep = wdata;
    endcase
  end

  assign wlane = {32'b0, wrep} << {offset, 3'b000};

  // Two-beat window shifted down so the addressed byte lands in lane 0.
  assign raw = 32'({beat1, beat0} >> {offset, 3'b000});

  // Truncate to size and extend according to the signed/unsigned variant.
  always_comb begin
    rdata = raw;
    case (func3)
      F3_B:    rdata = {{24{raw[7]}}, raw[7:0]};
      F3_BU:   rdata = {24'b0, raw[7:0]};
      F3_H:    rdata = {{16{raw[15]}}, raw[15:0]};
      F3_HU:   rdata = {16'b0, raw[15:0]};
      default: rdata = raw;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: RV32I load/store unit between execute and a word-addressed data memory.
// Latency: 3 cycles accept-to-rsp_valid aligned, 5 for a split, 1 for an error; beats stall on mem_gnt/mem_rvalid.
// One request in flight (req_ready only in IDLE). LSU_MISALIGNED_EN enables two-beat misaligned accesses.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       beat0_q, beat0_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_error_q, rsp_error_d;

  logic [7:0]        be8;
  logic [63:0]       wlane;
  logic [31:0]       ld_rdata;
  logic [31:0]       beat0_in;
  logic [31:0]       beat1_in;
  logic              spans;
  logic              hi_beat;
  logic              reject;
  logic [ADDR_W-1:0] word_addr;

  // Feed the live read word into the extractor during the completing wait state.
  assign beat0_in = (state_q == WAIT0) ? mem_rdata : beat0_q;
  assign beat1_in = (state_q == WAIT1) ? mem_rdata : 32'b0;

  lsu_align u_align (
    .func3  (f3_q),
    .offset (addr_q[1:0]),
    .wdata  (wdata_q),
    .beat0  (beat0_in),
    .beat1  (beat1_in),
    .be8    (be8),
    .wlane  (wlane),
    .rdata  (ld_rdata)
  );

  assign spans = |be8[7:4];

`ifdef LSU_MISALIGNED_EN
  assign reject = 1'b0;
`else
  assign reject = is_misaligned(req_func3, req_addr[1:0]);
`endif

  // Next-state and register-load decode for the request/beat/response sequence.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    beat0_d     = beat0_q;
    rsp_rdata_d = 32'b0;
    rsp_error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_func3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (!f3_legal(req_we, req_func3) || reject) begin
            state_d     = RESP;
            rsp_error_d = 1'b1;
          end else begin
            state_d = REQ0;
          end
        end
      end
      REQ0: if (mem_gnt) state_d = WAIT0;
      WAIT0: begin
        if (mem_rvalid) begin
          beat0_d = mem_rdata;
          if (spans) begin
            state_d = REQ1;
          end else begin
            state_d     = RESP;
            rsp_rdata_d = we_q ? 32'b0 : ld_rdata;
          end
        end
      end
      REQ1: if (mem_gnt) state_d = WAIT1;
      WAIT1: begin
        if (mem_rvalid) begin
          state_d     = RESP;
          rsp_rdata_d = we_q ? 32'b0 : ld_rdata;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'b0;
      addr_q      <= '0;
      wdata_q     <= 32'b0;
      beat0_q     <= 32'b0;
      rsp_rdata_q <= 32'b0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      beat0_q     <= beat0_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // Memory port is decoded from registered state only; zeroed whenever no beat is requested.
  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_req   = (state_q == REQ0) || (state_q == REQ1);
  assign hi_beat   = (state_q == REQ1);
  assign mem_addr  = !mem_req ? '0 : (hi_beat ? word_addr + ADDR_W'(4) : word_addr);
  assign mem_we    = mem_req && we_q;
  assign mem_be    = !mem_req ? 4'b0 : (hi_beat ? be8[7:4] : be8[3:0]);
  assign mem_wdata = !mem_req ? 32'b0 : (hi_beat ? wlane[63:32] : wlane[31:0]);

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule
